divider_seq_8bit: RTL and testbench

DIVIDER_SEQ_8BIT -- requirements
Module: divider_seq_8bit

---
 rtl/divider_pkg.sv | 17 +
 rtl/subtractor_8bit.sv | 14 +
 rtl/divider_seq_8bit.sv | 163 ++++++++++++++++
 tb/tb_divider_seq_8bit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing for the sequential 8-bit divider.
// Holds the FSM state encodings and the datapath/iteration widths.
package divider_pkg;

   localparam int DATA_W = 8;
   localparam int ITER   = 8;
   localparam int CNT_W  = $clog2(ITER);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : divider_pkg

// File: rtl/subtractor_8bit.sv
// Unsigned 8-bit subtractor used as the trial-subtraction datapath.
// d = a - b modulo 2^8; bout is set when b > a.
module subtractor_8bit
   import divider_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] d,
   output logic              bout
);

   assign {bout, d} = {1'b0, a} - {1'b0, b};

endmodule : subtractor_8bit

// File: rtl/divider_seq_8bit.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Defining DIV_ZERO_FLAG_EN adds the dz output and a one-cycle divide-by-zero path.
module divider_seq_8bit
   import divider_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] r,
   output logic              busy,
`ifdef DIV_ZERO_FLAG_EN
   output logic              done,
   output logic              dz
`else
   output logic              done
`endif
);

   state_t            state;
   state_t            state_next;

   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] divisor;
   logic [CNT_W-1:0]  cnt;

   logic [DATA_W:0]   partial;
   logic [DATA_W-1:0] diff;
   logic              borrow;
   logic              success;
   logic [DATA_W-1:0] rem_next;
   logic [DATA_W-1:0] quo_next;

   logic              accept;
   logic              iter_en;
   logic              last_iter;

`ifdef DIV_ZERO_FLAG_EN
   logic              fast_go;
   logic              fast_pend;
   logic              fast_fire;
`endif

   // Partial remainder gains the next dividend bit, shifted out of the quotient register.
   assign partial = {rem, quo[DATA_W-1]};

   subtractor_8bit u_sub (
      .a    (partial[DATA_W-1:0]),
      .b    (divisor),
      .d    (diff),
      .bout (borrow)
   );

   always_comb begin
      success  = partial[DATA_W] | ~borrow;
      rem_next = success ? diff : partial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], success};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      iter_en    = 1'b0;
      last_iter  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      fast_go    = 1'b0;
      fast_fire  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
               if (b == '0) begin
                  fast_go    = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = CALC;
               end
`else
               state_next = CALC;
`endif
            end
         end
         CALC: begin
            iter_en = 1'b1;
            if (cnt == CNT_LAST) begin
               last_iter  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
`ifdef DIV_ZERO_FLAG_EN
            fast_fire  = fast_pend;
`endif
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: datapath registers are reset as well, so an aborted division leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo       <= '0;
         rem       <= '0;
         divisor   <= '0;
         cnt       <= '0;
         q         <= '0;
         r         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         dz        <= 1'b0;
         fast_pend <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            divisor   <= b;
            quo       <= a;
            rem       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            dz        <= 1'b0;
            fast_pend <= fast_go;
`endif
         end else if (iter_en) begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
               q    <= quo_next;
               r    <= rem_next;
               busy <= 1'b0;
               done <= 1'b1;
            end
`ifdef DIV_ZERO_FLAG_EN
         end else if (fast_fire) begin
            // quo still holds the dividend latched at start.
            q         <= '1;
            r         <= quo;
            dz        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            fast_pend <= 1'b0;
`endif
         end
      end
   end

endmodule : divider_seq_8bit

// File: tb/tb_divider_seq_8bit.sv
// Directed scoreboard bench for divider_seq_8bit; build with DIV_ZERO_FLAG_EN
// defined to exercise the divide-by-zero fast path and dz flag.
module tb_divider_seq_8bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] q;
   logic [7:0] r;
   logic       busy;
   logic       done;
`ifdef DIV_ZERO_FLAG_EN
   logic       dz;
`endif

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         lat;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] held_q = 8'd0;
   logic [7:0] held_r = 8'd0;

   always #5 clk = ~clk;

   divider_seq_8bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .q     (q),
      .r     (r),
      .busy  (busy),
`ifdef DIV_ZERO_FLAG_EN
      .done  (done),
      .dz    (dz)
`else
      .done  (done)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      if (y == 8'd0) begin
         e.q = 8'hFF;
         e.r = x;
`ifdef DIV_ZERO_FLAG_EN
         e.dz  = 1'b1;
         e.lat = 1;
`else
         e.dz  = 1'b0;
         e.lat = 8;
`endif
      end else begin
         e.q   = x / y;
         e.r   = x % y;
         e.dz  = 1'b0;
         e.lat = 8;
      end
      return e;
   endfunction

   // Drives one accepted start at the current negedge; optionally pulses a
   // second start (240/224) at edge offset inject_at, which must be ignored.
   task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                         input int inject_at);
      int   lat;
      int   busy_cnt;
      logic held_ok;
      exp_t e;
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(model(x, y));
      @(negedge clk);
      start    = 1'b0;
      a        = 8'hAA;
      b        = 8'h55;
      lat      = 0;
      busy_cnt = 0;
      held_ok  = 1'b1;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         if (q !== held_q || r !== held_r) held_ok = 1'b0;
         if (lat == inject_at) begin
            a     = 8'd240;
            b     = 8'd224;
            start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      check({name, "_done_seen"}, done, 1);
      if (sb.size() == 0) begin
         check({name, "_sb_nonempty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({name, "_latency"}, lat, e.lat);
         check({name, "_busy_cycles"}, busy_cnt, e.lat);
         check({name, "_busy_low_at_done"}, busy, 0);
         check({name, "_q_r_held"}, held_ok, 1);
         check({name, "_q"}, q, e.q);
         check({name, "_r"}, r, e.r);
`ifdef DIV_ZERO_FLAG_EN
         check({name, "_dz"}, dz, e.dz);
`endif
         held_q = e.q;
         held_r = e.r;
         @(negedge clk);
         check({name, "_done_one_cycle"}, done, 0);
         check({name, "_q_hold"}, q, e.q);
         check({name, "_r_hold"}, r, e.r);
`ifdef DIV_ZERO_FLAG_EN
         check({name, "_dz_hold"}, dz, e.dz);
`endif
      end
   endtask

   initial begin
      int saw_done;
      rst_n = 1'b0;
      start = 1'b0;
      a     = 8'd0;
      b     = 8'd0;
      repeat (2) @(negedge clk);
      check("reset_q", q, 0);
      check("reset_r", r, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
`ifdef DIV_ZERO_FLAG_EN
      check("reset_dz", dz, 0);
`endif

      // Start presented together with reset release: the first high edge accepts it.
      rst_n = 1'b1;
      run_op("div165_147", 8'd165, 8'd147, -1);
      run_op("div200_7", 8'd200, 8'd7, -1);
      run_op("div5_9", 8'd5, 8'd9, -1);
      run_op("div255_1", 8'd255, 8'd1, -1);
      run_op("ignore_start", 8'd200, 8'd7, 3);
      run_op("div77_0", 8'd77, 8'd0, -1);
      run_op("div100_100", 8'd100, 8'd100, -1);

      // Abort a running 200/7 after its 4th iteration.
      a     = 8'd200;
      b     = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_q", q, 0);
      check("abort_r", r, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
`ifdef DIV_ZERO_FLAG_EN
      check("abort_dz", dz, 0);
`endif
      held_q = 8'd0;
      held_r = 8'd0;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) saw_done++;
      end
      check("abort_no_done", saw_done, 0);
      run_op("div240_224", 8'd240, 8'd224, -1);

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_divider_seq_8bit
